image_receiver: RTL and testbench
=================================

# image_receiver

Receives the RGB565 image payload that follows the 0x5A "start transport" command and writes it pixel by pixel into the frame buffer. It sits beside the three-state controller on the UART receive path. It watches the controller's `o_state` and raises `image_receiving` while a frame is in progress, so the controller ignores 0x5A data bytes until the full frame has arrived. Its write port drives the frame-buffer RAM that the display stage reads.

## Interface
Parameters:
- `IMG_W`, default 128: image width in pixels.
- `IMG_H`, default 128: image height in pixels.
- `ADDR_W`, default 14: frame-buffer address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.
- `TIMEOUT_CYCLES`, default 50_000_000: maximum idle gap between payload bytes (1 s at 50 MHz).

Ports:
- `i_clk_sys`, input, 1: system clock; the only clock.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_state`, input, 8: controller state code (01 wait, 02 transport, 03 display).
- `i_data`, input, 8: UART received byte.
- `i_rx_done`, input, 1: one-cycle pulse; `i_data` is valid in this cycle.
- `image_receiving`, output, 1: a frame is being received.
- `o_wr_en`, output, 1: frame-buffer write strobe, one cycle per pixel.
- `o_wr_addr`, output, ADDR_W: pixel index, row-major, starting at 0.
- `o_wr_data`, output, 16: RGB565 pixel, {high byte, low byte}.
- `o_frame_done`, output, 1: one-cycle pulse after the last pixel is written.
- `o_err`, output, 1: frame aborted (timeout or state left transport); sticky.

## Operation
- FSM states: IDLE, HI, LO, DONE, ERR. Register `st_d` holds the previous value of `i_state`.
- Entry event: `i_state == 8'h02 && st_d != 8'h02`. Any `i_rx_done` in the entry cycle is ignored.
- IDLE: all `i_rx_done` pulses are ignored. On the entry event:
  - go to HI
  - `image_receiving <= 1`
  - pixel index <= 0
  - `o_err <= 0`
  - timeout counter <= 0
- HI: on `i_rx_done`, latch `i_data` as the high byte, then go to LO.
- LO: on `i_rx_done`, perform the write:
  - `o_wr_data <= {hi, i_data}`, `o_wr_addr <=` pixel index, `o_wr_en <= 1` for one cycle.
  - If the index equals IMG_W*IMG_H-1: go to DONE, `image_receiving <= 0`, `o_frame_done <= 1` (same cycle as the final `o_wr_en`).
  - Otherwise: index +1, go to HI.
- Byte value 0x5A has no special meaning in HI or LO; it is stored as payload.
- DONE: further bytes are ignored. Return to IDLE when `i_state != 8'h02`.
- ERR: `image_receiving = 0` and `o_err = 1`. Return to IDLE when `i_state != 8'h02`. The partially written frame remains in the buffer.
- Abort: if `i_state != 8'h02` while in HI or LO:
  - go to IDLE
  - `image_receiving <= 0`
  - `o_err <= 1`
  - no write is issued, even if `i_rx_done` is present in the same cycle.
- Reset value of every output is 0: `image_receiving`, `o_wr_en`, `o_wr_addr`, `o_wr_data`, `o_frame_done`, `o_err`. FSM resets to IDLE.
- Reset mid-frame: immediate return to IDLE, outputs at 0. The frame is not resumed.

## Timing
- `image_receiving` rises 1 cycle after `i_state` first reads 02. This is 3 cycles after the 0x5A `i_rx_done`, which is well inside one UART byte time, so no payload byte is lost.
- Write latency: `o_wr_en` is asserted in the cycle after the low-byte `i_rx_done`.
- `o_wr_en` and `o_frame_done` are single-cycle pulses. No back-pressure; the RAM accepts every write.
- Pixel index never wraps. After IMG_W*IMG_H pixels the block stops writing.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES)+1`. It clears on entry and on every accepted `i_rx_done` in HI or LO, and increments in HI or LO otherwise.
- Simultaneous timeout expiry and `i_rx_done`: the byte wins, and the counter clears.

## Configuration
- `IMAGE_RECEIVER_TIMEOUT_EN` defined:
  - The timeout counter is present.
  - When the counter reaches TIMEOUT_CYCLES-1 in HI or LO, the next cycle enters ERR with `o_err = 1` and `image_receiving = 0`.
- Not defined:
  - No counter is synthesized.
  - HI and LO wait indefinitely.
  - ERR is reachable only through the abort path.

## Test plan
- Normal frame (IMG_W=IMG_H=2): `i_state` 01→02, then bytes 12 34 5A 5A AB CD EF 01. Required: writes (0,1234), (1,5A5A), (2,ABCD), (3,EF01); `image_receiving` falls in the same cycle as write 3; one `o_frame_done` pulse.
- Extra bytes after DONE (FF FF): no `o_wr_en`; `image_receiving` stays 0 until `i_state` returns to 01, and a later 01→02 restarts at address 0.
- Abort: `i_state` 02→03 after 3 bytes. Required: `o_err = 1`, `image_receiving = 0`, only 1 write issued, FSM in IDLE.
- Timeout (macro defined, TIMEOUT_CYCLES=100): one byte then silence. Required: `o_err` rises at cycle 100 after that byte; a later byte causes no write.
- Reset asserted mid-frame after 5 bytes: all outputs 0 immediately; after release and a new 01→02, the first write goes to address 0.
- `i_rx_done` in the entry cycle and while in IDLE: ignored, with no write and no change to the address.

Source files
------------

// File: rtl/image_receiver.sv
// image_receiver
//   Receives the RGB565 payload that follows the 0x5A "start transport"
//   command. Bytes arrive high byte first. Each completed byte pair is written
//   to the frame buffer as one pixel, in row-major order starting at index 0.
//   While a frame is in progress, image_receiving tells the controller to
//   treat 0x5A as payload rather than as a command.
//
// Optional feature macro: IMAGE_RECEIVER_TIMEOUT_EN
//   When defined, the block aborts to ERR if the gap between payload bytes
//   reaches TIMEOUT_CYCLES. When undefined, no counter is built and the
//   block waits indefinitely for the next byte.
//
// Ports
//   i_clk_sys        system clock
//   i_rst_n          asynchronous active-low reset
//   i_state[7:0]     controller state code (01 wait, 02 transport, 03 display)
//   i_data[7:0]      UART byte, valid while i_rx_done is high
//   i_rx_done        one-cycle byte strobe
//   image_receiving  high while a frame is being received
//   o_wr_en          frame-buffer write strobe, one cycle per pixel
//   o_wr_addr        pixel index
//   o_wr_data[15:0]  {high byte, low byte}
//   o_frame_done     one-cycle pulse, coincides with the final write
//   o_err            frame aborted; sticky until the next frame starts
module image_receiver #(
  parameter int unsigned IMG_W          = 128,
  parameter int unsigned IMG_H          = 128,
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  input  logic [7:0]        i_state,
  input  logic [7:0]        i_data,
  input  logic              i_rx_done,
  output logic              image_receiving,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [15:0]       o_wr_data,
  output logic              o_frame_done,
  output logic              o_err
);

  localparam logic [7:0]        ST_TRANSPORT = 8'h02;
  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q;
  logic [7:0]        st_d;      // previous i_state, for edge detection
  logic [7:0]        hi_q;
  logic [ADDR_W-1:0] idx_q;

  logic in_tx;
  logic entry;
  logic timeout_hit;

  assign in_tx = (i_state == ST_TRANSPORT);
  assign entry = in_tx && (st_d != ST_TRANSPORT);

`ifdef IMAGE_RECEIVER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == S_IDLE) begin
      if (entry) to_cnt_d = '0;
    end else if ((state_q == S_HI) || (state_q == S_LO)) begin
      if (i_rx_done) to_cnt_d = '0;
      else           to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end

  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;

  // Parameter is kept on the interface even when the counter is compiled out.
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= S_IDLE;
      st_d            <= '0;
      hi_q            <= '0;
      idx_q           <= '0;
      image_receiving <= 1'b0;
      o_wr_en         <= 1'b0;
      o_wr_addr       <= '0;
      o_wr_data       <= '0;
      o_frame_done    <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      st_d         <= i_state;
      o_wr_en      <= 1'b0;
      o_frame_done <= 1'b0;
      unique case (state_q)
        // A byte coinciding with the entry cycle is deliberately dropped.
        S_IDLE: begin
          if (entry) begin
            state_q         <= S_HI;
            image_receiving <= 1'b1;
            idx_q           <= '0;
            o_err           <= 1'b0;
          end
        end
        // Leaving transport has priority over a byte in the same cycle, and
        // a byte has priority over a timeout expiring in the same cycle.
        S_HI, S_LO: begin
          if (!in_tx) begin
            state_q         <= S_IDLE;
            image_receiving <= 1'b0;
            o_err           <= 1'b1;
          end else if (i_rx_done) begin
            if (state_q == S_HI) begin
              hi_q    <= i_data;
              state_q <= S_LO;
            end else begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= idx_q;
              o_wr_data <= {hi_q, i_data};
              if (idx_q == LAST_IDX) begin
                state_q         <= S_DONE;
                image_receiving <= 1'b0;
                o_frame_done    <= 1'b1;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= S_HI;
              end
            end
          end else if (timeout_hit) begin
            state_q         <= S_ERR;
            image_receiving <= 1'b0;
            o_err           <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          if (!in_tx) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_receiver.sv
module tb_image_receiver;

  localparam int unsigned IMG_W  = 2;
  localparam int unsigned IMG_H  = 2;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned TO_CYC = 100;
  localparam int unsigned NPIX   = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        st;
  logic [7:0]        data;
  logic              rx;
  logic              recv;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              fdone;
  logic              err;

  image_receiver #(
    .IMG_W          (IMG_W),
    .IMG_H          (IMG_H),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .i_clk_sys       (clk),
    .i_rst_n         (rst_n),
    .i_state         (st),
    .i_data          (data),
    .i_rx_done       (rx),
    .image_receiving (recv),
    .o_wr_en         (wr_en),
    .o_wr_addr       (wr_addr),
    .o_wr_data       (wr_data),
    .o_frame_done    (fdone),
    .o_err           (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic              recv;
    logic              fdone;
  } wr_t;

  wr_t         obs_q[$];
  logic [7:0]  mb_q[$];     // payload bytes the model expects to be accepted
  int unsigned fdone_cnt = 0;
  int unsigned fd_base   = 0;
  int unsigned n_checks  = 0;
  int unsigned n_errors  = 0;

  always @(negedge clk) begin
    if (wr_en) obs_q.push_back('{wr_addr, wr_data, recv, fdone});
    if (fdone) fdone_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    rx   = 1'b1;
    tick();
    rx   = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] b);
    mb_q.push_back(b);
    send_byte(b);
  endtask

  // 01 -> 02 transition; optionally a byte in the entry cycle (must be dropped)
  task automatic start_frame(input bit entry_byte);
    check("stray_wr", obs_q.size(), 0);
    st = 8'h01;
    tick();
    tick();
    st = 8'h02;
    if (entry_byte) begin
      data = 8'($urandom);
      rx   = 1'b1;
    end
    #2;
    check("recv_pre", recv, 0);
    tick();
    rx = 1'b0;
    check("recv_rise", recv, 1);
    check("err_clr", err, 0);
    mb_q.delete();
    obs_q.delete();
    fd_base = fdone_cnt;
  endtask

  // Model: pixel k is {byte 2k, byte 2k+1}; the index never wraps past NPIX.
  task automatic expect_frame(input string tag);
    int unsigned nexp;
    tick();
    nexp = mb_q.size() / 2;
    if (nexp > NPIX) nexp = NPIX;
    check({tag, "_nwr"}, obs_q.size(), nexp);
    check({tag, "_fdone_cnt"}, fdone_cnt - fd_base, (nexp == NPIX) ? 1 : 0);
    for (int k = 0; k < int'(nexp) && k < obs_q.size(); k++) begin
      check({tag, "_addr"}, obs_q[k].addr, k);
      check({tag, "_data"}, obs_q[k].data, {mb_q[2*k], mb_q[2*k+1]});
      check({tag, "_recv_at_wr"}, obs_q[k].recv, (k == int'(NPIX) - 1) ? 0 : 1);
      check({tag, "_fdone_at_wr"}, obs_q[k].fdone, (k == int'(NPIX) - 1) ? 1 : 0);
    end
    obs_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  norm_bytes [8];
    logic [7:0]  v;
    bit          ab;
    int unsigned nb;

    norm_bytes = '{8'h12, 8'h34, 8'h5A, 8'h5A, 8'hAB, 8'hCD, 8'hEF, 8'h01};
    rst_n = 1'b0;
    st    = 8'h01;
    data  = 8'h00;
    rx    = 1'b0;
    #23;
    check("rst_recv", recv, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_fdone", fdone, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Normal frame, then extra bytes after completion
    start_frame(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_payload(norm_bytes[i]);
      if (i % 3 == 1) tick();
    end
    send_payload(8'hFF);
    send_payload(8'hFF);
    expect_frame("norm");
    check("done_recv", recv, 0);
    check("done_err", err, 0);

    // Abort after 3 bytes; a byte in the abort cycle must not be written
    start_frame(1'b0);
    send_payload(8'h11);
    send_payload(8'h22);
    send_payload(8'h33);
    st   = 8'h03;
    data = 8'h44;
    rx   = 1'b1;
    tick();
    rx = 1'b0;
    check("abort_err", err, 1);
    check("abort_recv", recv, 0);
    expect_frame("abort");
    send_byte(8'h55);
    send_byte(8'h66);
    tick();
    check("err_sticky", err, 1);
    check("idle_recv", recv, 0);

`ifdef IMAGE_RECEIVER_TIMEOUT_EN
    // One byte then silence: o_err rises 100 cycles after the byte
    start_frame(1'b0);
    send_payload(8'hA5);
    repeat (TO_CYC - 1) tick();
    check("to_err_early", err, 0);
    check("to_recv_early", recv, 1);
    tick();
    check("to_err", err, 1);
    check("to_recv", recv, 0);
    send_byte(8'h3C);
    send_byte(8'hC3);
    expect_frame("to");
    st = 8'h01;
    tick();
`else
    // Without the timeout feature a long gap is harmless
    start_frame(1'b0);
    send_payload(8'hA5);
    repeat (3 * TO_CYC) tick();
    check("nto_err", err, 0);
    check("nto_recv", recv, 1);
    send_payload(8'h5A);
    st = 8'h01;
    tick();
    check("nto_abort_err", err, 1);
    expect_frame("nto");
`endif

    // Reset mid-frame after 5 bytes
    start_frame(1'b0);
    for (int i = 0; i < 5; i++) send_payload(8'($urandom));
    tick();
    #2;
    rst_n = 1'b0;
    st    = 8'h01;
    #1;
    check("mid_rst_recv", recv, 0);
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_addr", wr_addr, 0);
    check("mid_rst_data", wr_data, 0);
    check("mid_rst_fdone", fdone, 0);
    check("mid_rst_err", err, 0);
    expect_frame("pre_rst");
    rst_n = 1'b1;
    tick();
    start_frame(1'b0);
    send_payload(8'hDE);
    send_payload(8'hAD);
    expect_frame("post_rst");
    st = 8'h03;
    tick();

    // Bytes in IDLE and in the entry cycle are ignored
    st = 8'h01;
    send_byte(8'h77);
    send_byte(8'h88);
    tick();
    start_frame(1'b1);
    for (int i = 0; i < int'(2 * NPIX); i++) send_payload(8'($urandom));
    expect_frame("entry_byte");

    // Randomized frames: complete or aborted, random gaps, frequent 0x5A
    for (int it = 0; it < 10; it++) begin
      ab = ($urandom_range(0, 2) == 0);
      nb = ab ? $urandom_range(0, 2 * NPIX - 1) : 2 * NPIX + $urandom_range(0, 2);
      start_frame(1'($urandom_range(0, 1)));
      for (int b = 0; b < int'(nb); b++) begin
        v = ($urandom_range(0, 3) == 0) ? 8'h5A : 8'($urandom);
        send_payload(v);
        repeat ($urandom_range(0, 2)) tick();
      end
      if (ab) begin
        st   = 8'h03;
        data = 8'($urandom);
        rx   = 1'($urandom_range(0, 1));
        tick();
        rx = 1'b0;
        check("rand_abort_err", err, 1);
      end else begin
        check("rand_done_err", err, 0);
      end
      check("rand_recv", recv, 0);
      expect_frame("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
